// File: rtl/vga_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants, RGB332 layout and colour expansion.
package vga_scanout_pkg;

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_ACTIVE = 10'd640;
  localparam cnt_t H_FP     = 10'd16;
  localparam cnt_t H_SYNC   = 10'd96;
  localparam cnt_t H_TOTAL  = 10'd800;
  localparam cnt_t V_ACTIVE = 10'd480;
  localparam cnt_t V_FP     = 10'd10;
  localparam cnt_t V_SYNC   = 10'd2;
  localparam cnt_t V_TOTAL  = 10'd525;

  localparam cnt_t HS_BEG = H_ACTIVE + H_FP;
  localparam cnt_t HS_END = HS_BEG + H_SYNC;
  localparam cnt_t H_LAST = H_TOTAL - 10'd1;

  localparam int R_LSB = 5;
  localparam int G_LSB = 2;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Replicate MSBs so full-scale codes reach 4'hF.
  function automatic rgb_t rgb332(input logic [7:0] px);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = px[R_LSB +: 3];
    g = px[G_LSB +: 3];
    b = px[B_LSB +: 2];
    return '{r: {r, r[2]}, g: {g, g[2]}, b: {b, b}};
  endfunction

endpackage

// File: rtl/vga_scanout_timing.sv
// Pixel-tick divider plus horizontal/vertical counters and raw sync,
// active, vblank and frame interrupt flags.
module vga_scanout_timing
  import vga_scanout_pkg::*;
#(
  parameter int   TICK_DIV = 4,
  parameter cnt_t VACT     = V_ACTIVE,
  parameter cnt_t VFP      = V_FP,
  parameter cnt_t VSYNC    = V_SYNC,
  parameter cnt_t VTOTAL   = V_TOTAL
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o,
  output logic line_end_o,
  output logic frame_end_o,
  output logic active_o,
  output logic hs_o,
  output logic vs_o,
  output logic vblank_o,
  output logic frame_irq_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam cnt_t VS_BEG = VACT + VFP;
  localparam cnt_t VS_END = VS_BEG + VSYNC;
  localparam cnt_t V_LAST = VTOTAL - 10'd1;
  localparam cnt_t VA_LAST = VACT - 10'd1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic irq_q, irq_d;

  always_comb begin
    tick_o      = tcnt_q == TW'(TICK_DIV - 1);
    line_end_o  = hcnt_q == H_LAST;
    frame_end_o = line_end_o && (vcnt_q == V_LAST);
    active_o    = (hcnt_q < H_ACTIVE) && (vcnt_q < VACT);
    hs_o        = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_o        = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    vblank_o    = vcnt_q >= VACT;
    frame_irq_o = irq_q;
  end

  always_comb begin
    tcnt_d = tick_o ? '0 : tcnt_q + TW'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick_o) begin
      hcnt_d = line_end_o ? '0 : hcnt_q + 10'd1;
      if (line_end_o) begin
        vcnt_d = frame_end_o ? '0 : vcnt_q + 10'd1;
      end
    end
    // High only on the single rawclk that follows the 479->480 tick.
    irq_d = tick_o && line_end_o && (vcnt_q == VA_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// 64x48 RGB332 framebuffer scanner, 10x upscaled onto 640x480 VGA,
// with a two-stage address/colour pipeline on the pixel tick.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int   ADDR_WIDTH = 10,
  parameter int   DATA_WIDTH = 32,
  parameter int   TICK_DIV   = 4,
  parameter int   SCALE      = 10,
  parameter int   FB_W       = 64,
  parameter int   FB_H       = 48,
  parameter cnt_t VACT       = V_ACTIVE,
  parameter cnt_t VFP        = V_FP,
  parameter cnt_t VSYNC      = V_SYNC,
  parameter cnt_t VTOTAL     = V_TOTAL
) (
  input  logic                  rawclk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] dispAddr,
  input  logic [DATA_WIDTH-1:0] dispColor,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vblank,
  output logic                  frame_irq
);

  localparam int SW  = $clog2(SCALE);
  localparam int FXW = $clog2(FB_W);
  localparam int FYW = $clog2(FB_H);
  localparam logic [SW-1:0]  S_LAST  = SW'(SCALE - 1);
  localparam logic [FXW-1:0] FX_LAST = FXW'(FB_W - 1);
  localparam logic [FYW-1:0] FY_LAST = FYW'(FB_H - 1);

  logic tick, line_end, frame_end, active, hs, vs;

  vga_scanout_timing #(
    .TICK_DIV (TICK_DIV),
    .VACT     (VACT),
    .VFP      (VFP),
    .VSYNC    (VSYNC),
    .VTOTAL   (VTOTAL)
  ) u_timing (
    .clk_i       (rawclk),
    .rst_ni      (rst),
    .tick_o      (tick),
    .line_end_o  (line_end),
    .frame_end_o (frame_end),
    .active_o    (active),
    .hs_o        (hs),
    .vs_o        (vs),
    .vblank_o    (vblank),
    .frame_irq_o (frame_irq)
  );

  logic [SW-1:0]         hsub_q, hsub_d, vsub_q, vsub_d;
  logic [FXW-1:0]        fx_q, fx_d;
  logic [FYW-1:0]        fy_q, fy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            sel_q, sel_d;
  logic                  act_q, hs0_q, vs0_q;
  logic                  hs_q, vs_q;
  logic [7:0]            px;
  rgb_t                  rgb_q, rgb_d;

  // fx/fy saturate so the address never leaves the framebuffer.
  always_comb begin
    hsub_d = hsub_q;
    fx_d   = fx_q;
    vsub_d = vsub_q;
    fy_d   = fy_q;
    if (line_end) begin
      hsub_d = '0;
      fx_d   = '0;
      if (frame_end) begin
        vsub_d = '0;
        fy_d   = '0;
      end else if (vsub_q == S_LAST) begin
        vsub_d = '0;
        if (fy_q != FY_LAST) fy_d = fy_q + FYW'(1);
      end else begin
        vsub_d = vsub_q + SW'(1);
      end
    end else if (hsub_q == S_LAST) begin
      hsub_d = '0;
      if (fx_q != FX_LAST) fx_d = fx_q + FXW'(1);
    end else begin
      hsub_d = hsub_q + SW'(1);
    end
  end

  always_comb begin
    addr_d = active ? ADDR_WIDTH'({fy_q, fx_q[FXW-1:2]}) : addr_q;
    sel_d  = fx_q[1:0];
    px     = dispColor[{sel_q, 3'b000} +: 8];
    rgb_d  = act_q ? rgb332(px) : '0;
  end

  always_ff @(posedge rawclk or negedge rst) begin
    if (!rst) begin
      hsub_q <= '0;
      vsub_q <= '0;
      fx_q   <= '0;
      fy_q   <= '0;
      addr_q <= '0;
      sel_q  <= '0;
      act_q  <= 1'b0;
      hs0_q  <= 1'b1;
      vs0_q  <= 1'b1;
      rgb_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else if (tick) begin
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      fx_q   <= fx_d;
      fy_q   <= fy_d;
      addr_q <= addr_d;
      sel_q  <= sel_d;
      act_q  <= active;
      hs0_q  <= hs;
      vs0_q  <= vs;
      rgb_q  <= rgb_d;
      hs_q   <= hs0_q;
      vs_q   <= vs0_q;
    end
  end

  assign dispAddr = addr_q;
  assign vga_r    = rgb_q.r;
  assign vga_g    = rgb_q.g;
  assign vga_b    = rgb_q.b;
  assign vga_hs   = hs_q;
  assign vga_vs   = vs_q;

endmodule
